arith_seq: RTL and testbench

- Sequencer that executes one three-address arithmetic order on the arithmetic datapath: clear A, fetch operand 1 to A, fetch operand 2 to B, fire the order pulse, wait for the arithmetic-control answer, place the result in C, write it to memory.
- Sits between the order decoder (op) and the arithmetic control / memory.
- A watchdog turns a missing answer (division overflow aborts without answering) into an overflow report.

---
 rtl/arith_seq_pkg.sv | 53 +++++
 rtl/arith_seq_wdog.sv | 33 +++
 rtl/arith_seq.sv | 178 +++++++++++++++++
 tb/tb_arith_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_seq_pkg.sv
// Shared constants for the three-address arithmetic order sequencer:
// opcode encodings, one-hot state indices and the default watchdog limit.
package arith_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;

    localparam int DEF_TIMEOUT = 96;

    localparam int unsigned S_IDLE  = 0;
    localparam int unsigned S_ERR   = 1;
    localparam int unsigned S_CLR_A = 2;
    localparam int unsigned S_RD1   = 3;
    localparam int unsigned S_LD1   = 4;
    localparam int unsigned S_MV_A  = 5;
    localparam int unsigned S_RD2   = 6;
    localparam int unsigned S_LD2   = 7;
    localparam int unsigned S_MV_B  = 8;
    localparam int unsigned S_ORD   = 9;
    localparam int unsigned S_WAIT  = 10;
    localparam int unsigned S_FIX   = 11;
    localparam int unsigned S_WR    = 12;
    localparam int unsigned S_DONE  = 13;
    localparam int unsigned S_OVF   = 14;
    localparam int unsigned S_ABT   = 15;

    typedef enum logic [15:0] {
        IDLE     = 16'd1 << S_IDLE,
        ERR      = 16'd1 << S_ERR,
        CLR_A    = 16'd1 << S_CLR_A,
        RD1      = 16'd1 << S_RD1,
        LD1      = 16'd1 << S_LD1,
        MV_A     = 16'd1 << S_MV_A,
        RD2      = 16'd1 << S_RD2,
        LD2      = 16'd1 << S_LD2,
        MV_B     = 16'd1 << S_MV_B,
        ORD      = 16'd1 << S_ORD,
        WAIT_ANS = 16'd1 << S_WAIT,
        FIX      = 16'd1 << S_FIX,
        WR       = 16'd1 << S_WR,
        DONE     = 16'd1 << S_DONE,
        OVF      = 16'd1 << S_OVF,
        ABT      = 16'd1 << S_ABT
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_AND);
    endfunction

endpackage

// File: rtl/arith_seq_wdog.sv
// Watchdog for the arithmetic-control answer: cleared when the order fires,
// counts while waiting, flags expiry on the last allowed cycle.
module arith_seq_wdog
    import arith_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_r;

    // Wait-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/arith_seq.sv
// Sequencer for one three-address arithmetic order: load A and B from memory,
// fire the order, wait for the answer (with watchdog), write C back.
module arith_seq
    import arith_seq_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_from_op,
    input  logic [2:0]        opcode_from_op,
    input  logic [ADDR_W-1:0] addr1_from_op,
    input  logic [ADDR_W-1:0] addr2_from_op,
    input  logic [ADDR_W-1:0] addr3_from_op,
    input  logic              abort_from_op,
    input  logic              mem_ack_from_mem,
    input  logic              ac_answer_from_ac,
    output logic              mem_rd_req_to_mem,
    output logic              mem_wr_req_to_mem,
    output logic [ADDR_W-1:0] mem_addr_to_mem,
    output logic              do_clear_a_to_ac,
    output logic              do_mem_to_c_to_ac,
    output logic              do_move_c_to_a_to_ac,
    output logic              do_move_c_to_b_to_ac,
    output logic              do_move_b_to_c_to_ac,
    output logic              order_add_to_ac,
    output logic              order_sub_to_ac,
    output logic              order_mul_to_ac,
    output logic              order_div_to_ac,
    output logic              order_and_to_ac,
    output logic              busy_to_op,
    output logic              done_to_op,
    output logic              ovf_to_op,
    output logic              illegal_to_op
);

    state_e            state_r;
    state_e            state_s;
    logic [2:0]        opcode_r;
    logic [ADDR_W-1:0] addr1_r;
    logic [ADDR_W-1:0] addr2_r;
    logic [ADDR_W-1:0] addr3_r;
    logic [ADDR_W-1:0] addr_s;
    logic              wd_expired_s;

    arith_seq_wdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_r == ORD),
        .en      (state_r == WAIT_ANS),
        .expired (wd_expired_s)
    );

    // Next-state logic; abort overrides everything except idle and abort itself
    always_comb begin
        state_s = state_r;
        if ((state_r != IDLE) && (state_r != ABT) && abort_from_op) begin
            state_s = ABT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_from_op) begin
                        if (op_legal(opcode_from_op)) begin
                            state_s = CLR_A;
                        end else begin
                            state_s = ERR;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                CLR_A:    state_s = RD1;
                RD1:      state_s = mem_ack_from_mem ? LD1 : RD1;
                LD1:      state_s = MV_A;
                MV_A:     state_s = RD2;
                RD2:      state_s = mem_ack_from_mem ? LD2 : RD2;
                LD2:      state_s = MV_B;
                MV_B:     state_s = ORD;
                ORD:      state_s = WAIT_ANS;
                WAIT_ANS: begin
                    // an answer on the expiry cycle still counts
                    if (ac_answer_from_ac) begin
                        if ((opcode_r == OP_DIV) || (opcode_r == OP_AND)) begin
                            state_s = FIX;
                        end else begin
                            state_s = WR;
                        end
                    end else if (wd_expired_s) begin
                        state_s = OVF;
                    end else begin
                        state_s = WAIT_ANS;
                    end
                end
                FIX:      state_s = WR;
                WR:       state_s = mem_ack_from_mem ? DONE : WR;
                default:  state_s = IDLE;
            endcase
        end
    end

    // Address for the request of the upcoming state
    always_comb begin
        case (state_s)
            RD1:     addr_s = addr1_r;
            RD2:     addr_s = addr2_r;
            WR:      addr_s = addr3_r;
            default: addr_s = '0;
        endcase
    end

    // State register and operand latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            opcode_r <= 3'd0;
            addr1_r  <= '0;
            addr2_r  <= '0;
            addr3_r  <= '0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && start_from_op) begin
                opcode_r <= opcode_from_op;
                addr1_r  <= addr1_from_op;
                addr2_r  <= addr2_from_op;
                addr3_r  <= addr3_from_op;
            end else begin
                opcode_r <= opcode_r;
                addr1_r  <= addr1_r;
                addr2_r  <= addr2_r;
                addr3_r  <= addr3_r;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rd_req_to_mem    <= 1'b0;
            mem_wr_req_to_mem    <= 1'b0;
            mem_addr_to_mem      <= '0;
            do_clear_a_to_ac     <= 1'b0;
            do_mem_to_c_to_ac    <= 1'b0;
            do_move_c_to_a_to_ac <= 1'b0;
            do_move_c_to_b_to_ac <= 1'b0;
            do_move_b_to_c_to_ac <= 1'b0;
            order_add_to_ac      <= 1'b0;
            order_sub_to_ac      <= 1'b0;
            order_mul_to_ac      <= 1'b0;
            order_div_to_ac      <= 1'b0;
            order_and_to_ac      <= 1'b0;
            busy_to_op           <= 1'b0;
            done_to_op           <= 1'b0;
            ovf_to_op            <= 1'b0;
            illegal_to_op        <= 1'b0;
        end else begin
            mem_rd_req_to_mem    <= (state_s == RD1) || (state_s == RD2);
            mem_wr_req_to_mem    <= (state_s == WR);
            mem_addr_to_mem      <= addr_s;
            do_clear_a_to_ac     <= (state_s == CLR_A) || (state_s == OVF) || (state_s == ABT);
            do_mem_to_c_to_ac    <= (state_s == LD1) || (state_s == LD2);
            do_move_c_to_a_to_ac <= (state_s == MV_A);
            do_move_c_to_b_to_ac <= (state_s == MV_B);
            do_move_b_to_c_to_ac <= (state_s == FIX);
            order_add_to_ac      <= (state_s == ORD) && (opcode_r == OP_ADD);
            order_sub_to_ac      <= (state_s == ORD) && (opcode_r == OP_SUB);
            order_mul_to_ac      <= (state_s == ORD) && (opcode_r == OP_MUL);
            order_div_to_ac      <= (state_s == ORD) && (opcode_r == OP_DIV);
            order_and_to_ac      <= (state_s == ORD) && (opcode_r == OP_AND);
            busy_to_op           <= (state_s != IDLE);
            done_to_op           <= (state_s == DONE);
            ovf_to_op            <= (state_s == OVF);
            illegal_to_op        <= (state_s == ERR);
        end
    end

endmodule

// File: tb/tb_arith_seq.sv
// Directed self-checking bench for arith_seq: every cycle of each order is
// compared against a hand-written expected output vector.
module tb_arith_seq;

    localparam int TIMEOUT = 96;

    localparam logic [12:0] P_NONE = 13'h0000;
    localparam logic [12:0] P_CLR  = 13'h1000;
    localparam logic [12:0] P_M2C  = 13'h0800;
    localparam logic [12:0] P_C2A  = 13'h0400;
    localparam logic [12:0] P_C2B  = 13'h0200;
    localparam logic [12:0] P_B2C  = 13'h0100;
    localparam logic [12:0] P_ADD  = 13'h0080;
    localparam logic [12:0] P_SUB  = 13'h0040;
    localparam logic [12:0] P_MUL  = 13'h0020;
    localparam logic [12:0] P_DIV  = 13'h0010;
    localparam logic [12:0] P_AND  = 13'h0008;
    localparam logic [12:0] P_DONE = 13'h0004;
    localparam logic [12:0] P_OVF  = 13'h0002;
    localparam logic [12:0] P_ILL  = 13'h0001;

    logic        clk = 1'b0;
    logic        reset, start, abort, mem_ack, ac_answer;
    logic [2:0]  opcode;
    logic [11:0] addr1, addr2, addr3;
    logic        rd_req, wr_req, busy;
    logic [11:0] mem_addr;
    logic        clr_a, m2c, c2a, c2b, b2c, o_add, o_sub, o_mul, o_div, o_and;
    logic        done, ovf, illegal;
    logic [12:0] pulses;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    always #5 clk = ~clk;

    arith_seq dut (
        .clk                  (clk),
        .reset                (reset),
        .start_from_op        (start),
        .opcode_from_op       (opcode),
        .addr1_from_op        (addr1),
        .addr2_from_op        (addr2),
        .addr3_from_op        (addr3),
        .abort_from_op        (abort),
        .mem_ack_from_mem     (mem_ack),
        .ac_answer_from_ac    (ac_answer),
        .mem_rd_req_to_mem    (rd_req),
        .mem_wr_req_to_mem    (wr_req),
        .mem_addr_to_mem      (mem_addr),
        .do_clear_a_to_ac     (clr_a),
        .do_mem_to_c_to_ac    (m2c),
        .do_move_c_to_a_to_ac (c2a),
        .do_move_c_to_b_to_ac (c2b),
        .do_move_b_to_c_to_ac (b2c),
        .order_add_to_ac      (o_add),
        .order_sub_to_ac      (o_sub),
        .order_mul_to_ac      (o_mul),
        .order_div_to_ac      (o_div),
        .order_and_to_ac      (o_and),
        .busy_to_op           (busy),
        .done_to_op           (done),
        .ovf_to_op            (ovf),
        .illegal_to_op        (illegal)
    );

    assign pulses = {clr_a, m2c, c2a, c2b, b2c, o_add, o_sub, o_mul, o_div, o_and,
                     done, ovf, illegal};

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk_o(input string t, input logic [11:0] a, input logic rd,
                         input logic wr, input logic bsy, input logic [12:0] p);
        logic [27:0] obs;
        logic [27:0] exp;
        obs = {mem_addr, rd_req, wr_req, busy, pulses};
        exp = {a, rd, wr, bsy, p};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, obs, exp);
        end
    endtask

    task automatic chk_lat(input string t, input int exp);
        total++;
        assert ((cyc - t0) === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", t, cyc - t0, exp);
        end
    endtask

    task automatic do_start(input logic [2:0] op, input logic [11:0] a1,
                            input logic [11:0] a2, input logic [11:0] a3);
        opcode = op;
        addr1  = a1;
        addr2  = a2;
        addr3  = a3;
        start  = 1'b1;
        t0     = cyc;
        tick();
        start  = 1'b0;
    endtask

    // cycles 1..6: CLR_A, RD1 (ack in 2nd cycle), LD1, MV_A, first RD2 cycle
    task automatic part_a(input string t, input logic [11:0] a1, input logic [11:0] a2);
        chk_o({t, ":clr"}, 12'h0, 1'b0, 1'b0, 1'b1, P_CLR);
        tick();
        chk_o({t, ":rd1a"}, a1, 1'b1, 1'b0, 1'b1, P_NONE);
        tick();
        chk_o({t, ":rd1b"}, a1, 1'b1, 1'b0, 1'b1, P_NONE);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_o({t, ":ld1"}, 12'h0, 1'b0, 1'b0, 1'b1, P_M2C);
        tick();
        chk_o({t, ":mva"}, 12'h0, 1'b0, 1'b0, 1'b1, P_C2A);
        tick();
        chk_o({t, ":rd2a"}, a2, 1'b1, 1'b0, 1'b1, P_NONE);
    endtask

    // cycles 7..11: second RD2 cycle, LD2, MV_B, ORD, first WAIT_ANS cycle
    task automatic part_b(input string t, input logic [11:0] a2, input logic [12:0] ord);
        tick();
        chk_o({t, ":rd2b"}, a2, 1'b1, 1'b0, 1'b1, P_NONE);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_o({t, ":ld2"}, 12'h0, 1'b0, 1'b0, 1'b1, P_M2C);
        tick();
        chk_o({t, ":mvb"}, 12'h0, 1'b0, 1'b0, 1'b1, P_C2B);
        tick();
        chk_o({t, ":ord"}, 12'h0, 1'b0, 1'b0, 1'b1, ord);
        tick();
        chk_o({t, ":wait"}, 12'h0, 1'b0, 1'b0, 1'b1, P_NONE);
    endtask

    // answer in the current wait cycle, optional FIX, WR (ack in 2nd cycle), DONE, IDLE
    task automatic tail(input string t, input logic [11:0] a3, input bit fix, input int lat);
        ac_answer = 1'b1;
        tick();
        ac_answer = 1'b0;
        if (fix) begin
            chk_o({t, ":fix"}, 12'h0, 1'b0, 1'b0, 1'b1, P_B2C);
            tick();
        end
        chk_o({t, ":wr1"}, a3, 1'b0, 1'b1, 1'b1, P_NONE);
        tick();
        chk_o({t, ":wr2"}, a3, 1'b0, 1'b1, 1'b1, P_NONE);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_o({t, ":done"}, 12'h0, 1'b0, 1'b0, 1'b1, P_DONE);
        chk_lat({t, ":lat"}, lat);
        tick();
        chk_o({t, ":idle"}, 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mem_ack = 1'b0; ac_answer = 1'b0;
        opcode = 3'd0; addr1 = 12'h0; addr2 = 12'h0; addr3 = 12'h0;
        tick();
        tick();
        chk_o("reset", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);
        reset = 1'b0;
        tick();
        chk_o("idle0", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);

        // add: done 14 cycles after start, no move_b_to_c
        do_start(3'd0, 12'd5, 12'd6, 12'd7);
        part_a("add", 12'd5, 12'd6);
        part_b("add", 12'd6, P_ADD);
        tail("add", 12'd7, 1'b0, 14);

        // div, answer after 63 wait cycles; a start while busy is ignored
        do_start(3'd3, 12'h100, 12'h101, 12'h102);
        part_a("div", 12'h100, 12'h101);
        part_b("div", 12'h101, P_DIV);
        for (int k = 2; k <= 63; k++) begin
            start  = (k == 5);
            opcode = 3'd6;
            tick();
            chk_o("div:wait", 12'h0, 1'b0, 1'b0, 1'b1, P_NONE);
        end
        start = 1'b0;
        tail("div", 12'h102, 1'b1, 77);
        tick();
        chk_o("div:once", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);

        // div overflow: OVF TIMEOUT cycles after entering WAIT_ANS
        do_start(3'd3, 12'h200, 12'h201, 12'h202);
        part_a("ovf", 12'h200, 12'h201);
        part_b("ovf", 12'h201, P_DIV);
        for (int k = 2; k <= TIMEOUT; k++) begin
            tick();
            chk_o("ovf:wait", 12'h0, 1'b0, 1'b0, 1'b1, P_NONE);
        end
        tick();
        chk_o("ovf:pulse", 12'h0, 1'b0, 1'b0, 1'b1, P_OVF | P_CLR);
        chk_lat("ovf:lat", 10 + TIMEOUT + 1);
        tick();
        chk_o("ovf:idle", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);

        // answer on the expiry cycle wins over overflow
        do_start(3'd3, 12'h300, 12'h301, 12'h302);
        part_a("edge", 12'h300, 12'h301);
        part_b("edge", 12'h301, P_DIV);
        for (int k = 2; k <= TIMEOUT; k++) begin
            tick();
            chk_o("edge:wait", 12'h0, 1'b0, 1'b0, 1'b1, P_NONE);
        end
        tail("edge", 12'h302, 1'b1, 110);

        // and: result fixed up from B
        do_start(3'd4, 12'h0a1, 12'h0a2, 12'h0a3);
        part_a("and", 12'h0a1, 12'h0a2);
        part_b("and", 12'h0a2, P_AND);
        tail("and", 12'h0a3, 1'b1, 15);

        // illegal opcode; second start during ERR ignored
        do_start(3'd6, 12'h011, 12'h012, 12'h013);
        chk_o("ill:pulse", 12'h0, 1'b0, 1'b0, 1'b1, P_ILL);
        opcode = 3'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk_o("ill:idle", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);
        tick();
        chk_o("ill:still", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);

        // abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_o("abt:idle", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);

        // abort while RD2 waits; late ack is ignored
        do_start(3'd0, 12'h021, 12'h022, 12'h023);
        part_a("abt", 12'h021, 12'h022);
        tick();
        chk_o("abt:rd2b", 12'h022, 1'b1, 1'b0, 1'b1, P_NONE);
        tick();
        chk_o("abt:rd2c", 12'h022, 1'b1, 1'b0, 1'b1, P_NONE);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_o("abt:clr", 12'h0, 1'b0, 1'b0, 1'b1, P_CLR);
        tick();
        chk_o("abt:idle", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_o("abt:lateack", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);
        tick();
        chk_o("abt:after", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);

        // reset in WAIT_ANS together with an answer
        do_start(3'd2, 12'h031, 12'h032, 12'h033);
        part_a("rst", 12'h031, 12'h032);
        part_b("rst", 12'h032, P_MUL);
        reset     = 1'b1;
        ac_answer = 1'b1;
        tick();
        reset     = 1'b0;
        ac_answer = 1'b0;
        chk_o("rst:zero", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);
        tick();
        chk_o("rst:nodone", 12'h0, 1'b0, 1'b0, 1'b0, P_NONE);

        // fresh order after reset
        do_start(3'd1, 12'h041, 12'h042, 12'h043);
        part_a("sub", 12'h041, 12'h042);
        part_b("sub", 12'h042, P_SUB);
        tail("sub", 12'h043, 1'b0, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
